apb_pad_reader: RTL
===================

# apb_pad_reader

APB3 slave that scans NUM_PADS NES/SNES-style serial gamepads over shared latch/clock lines and publishes debounced-by-scan button words to the processor. It supersedes the single 8-bit controller reader in the game peripheral with parametrised pad count and bit width, continuous or one-shot scanning, and sticky press-edge events with an interrupt. It sits on the fabric APB bus beside the VGA and sound registers.

## Interface
- NUM_PADS, 2, number of pads sharing pad_latch/pad_clock (1–4)
- PAD_BITS, 8, bits shifted per pad per scan (8 = NES, 16 = SNES; 2–16)
- DIV_MAX, 150, tick divider terminal count; one tick = DIV_MAX+1 PCLK cycles
- POLL_TICKS, 64, idle ticks between continuous scans (≥1)
- PCLK  in  1  clock; all state on rising edge
- PRESERN  in  1  asynchronous, active-low reset
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  12  byte address; only [11:0] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- pad_latch  out  1  shared latch strobe to pads
- pad_clock  out  1  shared shift clock to pads
- pad_data  in  NUM_PADS  serial data per pad, active-low (pressed = 0)
- irq  out  1  level interrupt to fabric

## Operation
- Register map: 0x000 CTRL (RW: [0] run, [1] irq_en, [2] oneshot, write-1 self-clearing, reads 0); 0x004 STATUS (RO: [0] busy, [1] valid; W1C on [1]); 0x010+4·i PAD_i (RO, [PAD_BITS-1:0] pressed = 1); 0x020+4·i PRESS_i (W1C sticky press edges). Unmapped/unused-pad addresses read 0, writes ignored.
- Write strobe: PSEL & PENABLE & PWRITE. PRDATA is combinational decode when PSEL & ~PWRITE, else 0.
- Tick: divider counts 0..DIV_MAX, tick asserted for one PCLK when count == DIV_MAX; counter free-runs from reset.
- FSM states IDLE, LATCH, SAMPLE, CLK, COMMIT:
  - IDLE: leave on tick when (run & gap counter == 0) or oneshot pending → LATCH; gap counter decrements per tick.
  - LATCH: pad_latch=1 for one tick → SAMPLE.
  - SAMPLE: at tick, shift ~pad_data[i] into shift_i LSB (left shift; first bit ends in bit PAD_BITS-1); bit count +1; last bit → COMMIT, else → CLK.
  - CLK: pad_clock=1 for one tick → SAMPLE.
  - COMMIT (one PCLK, no tick needed): PAD_i ← shift_i; PRESS_i |= shift_i & ~PAD_i(old); valid ← 1; gap counter ← POLL_TICKS; oneshot pending cleared → IDLE.
- busy = state ≠ IDLE.
- irq = irq_en & (OR of all PRESS_i bits).

## Timing
- Reset values: PRDATA 0, pad_latch 0, pad_clock 0, irq 0, all registers 0, state IDLE, gap counter 0, divider 0.
- Scan length: 2·PAD_BITS ticks from LATCH entry to COMMIT entry (1 latch + PAD_BITS samples + PAD_BITS−1 clocks); PAD_i visible on PRDATA the PCLK after COMMIT.
- pad_latch and pad_clock are registered, never high simultaneously, each high exactly DIV_MAX+1 cycles.
- Boundaries:
  - run cleared mid-scan: scan completes and commits, then stays IDLE.
  - oneshot while busy: ignored (not queued).
  - W1C on PRESS/valid in same cycle as COMMIT setting that bit: set wins.
  - First scan after reset: old PAD = 0, so held buttons produce press events.
  - Reset asserted mid-scan: all outputs and state return to reset values asynchronously; no partial commit.
  - Widths: divider $clog2(DIV_MAX+1), bit counter $clog2(PAD_BITS), gap counter $clog2(POLL_TICKS+1); no overflow possible.

## Configuration
- PAD_PRESS_EVT_EN defined: PRESS_i registers, edge detection and irq as above.
- Not defined: PRESS_i read 0, writes ignored, no edge logic synthesised, irq tied 0; CTRL[1] reads 0.

## Test plan
- NUM_PADS=2, PAD_BITS=8, DIV_MAX=3: after reset, pad_latch/pad_clock/irq = 0, all reads 0, busy 0.
- Write CTRL=0x4 (oneshot), pad0 model drives 0xA5 pressed (lines low), pad1 0x00 → one latch pulse, 7 clock pulses, COMMIT 64 cycles after LATCH; PAD_0=0x000000A5, PAD_1=0, STATUS=0x2.
- Event path (macro on): CTRL=0x2 then oneshot with pad0=0x01 → PRESS_0=0x01, irq=1; write 0x1 to 0x020 → PRESS_0=0, irq=0; rescan same input → no new event.
- Continuous: CTRL=0x1, POLL_TICKS=4 → successive LATCH entries 20 ticks (80 PCLK) apart; clear run mid-scan → scan commits, no further latch.
- Simultaneous W1C to PRESS_0 bit0 in COMMIT cycle that sets it → bit0 reads 1.
- Drop PRESERN during 4th SAMPLE → outputs 0 same cycle; PAD_0 retains 0, not a partial value.

Source files
------------

// File: rtl/apb_pad_reader.sv
// rtl/apb_pad_reader.sv - APB3 serial gamepad scanner; optional press events/irq under `PAD_PRESS_EVT_EN
module apb_pad_reader #(
   parameter int NUM_PADS   = 2,
   parameter int PAD_BITS   = 8,
   parameter int DIV_MAX    = 150,
   parameter int POLL_TICKS = 64
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [11:0]         PADDR,
   input  logic [31:0]         PWDATA,
   output logic [31:0]         PRDATA,
   output logic                PREADY,
   output logic                PSLVERR,
   output logic                pad_latch,
   output logic                pad_clock,
   input  logic [NUM_PADS-1:0] pad_data,
   output logic                irq
);

   localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
   localparam int BIT_W = $clog2(PAD_BITS);
   localparam int GAP_W = $clog2(POLL_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_SAMPLE,
      S_CLK,
      S_COMMIT
   } state_t;

   state_t                            state_q, state_d;
   logic [DIV_W-1:0]                  div_q;
   logic                              tick;
   logic [GAP_W-1:0]                  gap_q, gap_d, gap_dec;
   logic [BIT_W-1:0]                  bitcnt_q, bitcnt_d;
   logic [NUM_PADS-1:0][PAD_BITS-1:0] shift_q;
   logic [NUM_PADS-1:0][PAD_BITS-1:0] pad_q;
   logic [NUM_PADS-1:0]               sync1_q, sync2_q;
   logic                              run_q, oneshot_q, valid_q;
   logic                              latch_q, clock_q;
   logic                              busy;
   logic                              wr_en, wr_ctrl, wr_status;
   logic [9:0]                        word;
   logic                              irq_en_rd;
   logic                              unused_bits;

   assign PREADY      = 1'b1;
   assign PSLVERR     = 1'b0;
   assign pad_latch   = latch_q;
   assign pad_clock   = clock_q;
   assign busy        = (state_q != S_IDLE);
   assign word        = PADDR[11:2];
   assign wr_en       = PSEL & PENABLE & PWRITE;
   assign wr_ctrl     = wr_en && (word == 10'h000);
   assign wr_status   = wr_en && (word == 10'h001);
   assign unused_bits = ^{PWDATA, PADDR[1:0]};

   // Free-running divider; tick is one PCLK wide every DIV_MAX+1 cycles
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN)  div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + DIV_W'(1);
   end

   assign tick = (div_q == DIV_W'(DIV_MAX));

   // The gap is counted down on idle ticks; a continuous scan starts on the tick that empties it
   assign gap_dec = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);

   // Scan sequencer state register
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q  <= S_IDLE;
         gap_q    <= '0;
         bitcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   // Scan sequencer next state: latch, then alternate sample/clock until the last bit
   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      bitcnt_d = bitcnt_q;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               gap_d = gap_dec;
               if ((run_q && (gap_dec == '0)) || oneshot_q) state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            if (tick) begin
               state_d  = S_SAMPLE;
               bitcnt_d = '0;
            end
         end
         S_SAMPLE: begin
            if (tick) begin
               if (bitcnt_q == BIT_W'(PAD_BITS - 1)) begin
                  state_d = S_COMMIT;
               end else begin
                  bitcnt_d = bitcnt_q + BIT_W'(1);
                  state_d  = S_CLK;
               end
            end
         end
         S_CLK: begin
            if (tick) state_d = S_SAMPLE;
         end
         S_COMMIT: begin
            state_d  = S_IDLE;
            gap_d    = GAP_W'(POLL_TICKS);
            bitcnt_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pad strobes are registered from the next state so they are glitch-free and exclusive
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         latch_q <= 1'b0;
         clock_q <= 1'b0;
      end else begin
         latch_q <= (state_d == S_LATCH);
         clock_q <= (state_d == S_CLK);
      end
   end

   // Pad inputs come from off-chip; resynchronise, then shift inverted (pressed = 1) MSB-first
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         sync1_q <= '1;
         sync2_q <= '1;
         shift_q <= '0;
         pad_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sync1_q <= pad_data;
         sync2_q <= sync1_q;
         if (state_q == S_SAMPLE && tick) begin
            for (int i = 0; i < NUM_PADS; i++) begin
               shift_q[i] <= {shift_q[i][PAD_BITS-2:0], ~sync2_q[i]};
            end
         end
         if (state_q == S_COMMIT) begin
            pad_q   <= shift_q;
            valid_q <= 1'b1;
         end else if (wr_status && PWDATA[1]) begin
            valid_q <= 1'b0;
         end
      end
   end

   // CTRL run bit and one-shot request; a one-shot arriving mid-scan is dropped, not queued
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         run_q     <= 1'b0;
         oneshot_q <= 1'b0;
      end else begin
         if (wr_ctrl) run_q <= PWDATA[0];
         if (state_q == S_COMMIT)                  oneshot_q <= 1'b0;
         else if (wr_ctrl && PWDATA[2] && !busy)   oneshot_q <= 1'b1;
      end
   end

`ifdef PAD_PRESS_EVT_EN
   logic                              irq_en_q;
   logic [NUM_PADS-1:0][PAD_BITS-1:0] press_q;
   logic [NUM_PADS-1:0][PAD_BITS-1:0] press_clr;

   // Write-1-clear masks for the PRESS registers
   always_comb begin
      press_clr = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (wr_en && (word == 10'(8 + i))) press_clr[i] = PWDATA[PAD_BITS-1:0];
      end
   end

   // Sticky press edges against the previous committed word; a new edge beats a same-cycle clear
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         irq_en_q <= 1'b0;
         press_q  <= '0;
      end else begin
         if (wr_ctrl) irq_en_q <= PWDATA[1];
         for (int i = 0; i < NUM_PADS; i++) begin
            if (state_q == S_COMMIT)
               press_q[i] <= (press_q[i] & ~press_clr[i]) | (shift_q[i] & ~pad_q[i]);
            else
               press_q[i] <= press_q[i] & ~press_clr[i];
         end
      end
   end

   assign irq       = irq_en_q & (|press_q);
   assign irq_en_rd = irq_en_q;
`else
   assign irq       = 1'b0;
   assign irq_en_rd = 1'b0;
`endif

   // Combinational read decode; unmapped and unused-pad words read zero
   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         if (word == 10'h000) PRDATA = {29'd0, 1'b0, irq_en_rd, run_q};
         if (word == 10'h001) PRDATA = {30'd0, valid_q, busy};
         for (int i = 0; i < NUM_PADS; i++) begin
            if (word == 10'(4 + i)) PRDATA = 32'(pad_q[i]);
`ifdef PAD_PRESS_EVT_EN
            if (word == 10'(8 + i)) PRDATA = 32'(press_q[i]);
`endif
         end
      end
   end

endmodule
